// File: rtl/dvi_timing_gen.sv
// Parametrised DVI/VGA raster timing generator: pixel-enabled h/v counters,
// sync/active decode, and a PIPE-deep output register chain for alignment.
module dvi_timing_gen #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIPE       = 0,
  localparam int unsigned H_TOTAL   = H_RES + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_RES + V_FP + V_SYNC + V_BP,
  localparam int unsigned X_W       = $clog2(H_TOTAL),
  localparam int unsigned Y_W       = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pix_tick,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned OW = 6 + X_W + Y_W;

  localparam logic [X_W-1:0] H_MAX = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_TOTAL - 1);

  // Window bounds kept 32-bit so an end bound equal to the total still fits.
  localparam logic [31:0] H_SYNC_START = 32'(H_RES + H_FP);
  localparam logic [31:0] H_SYNC_END   = 32'(H_RES + H_FP + H_SYNC);
  localparam logic [31:0] V_SYNC_START = 32'(V_RES + V_FP);
  localparam logic [31:0] V_SYNC_END   = 32'(V_RES + V_FP + V_SYNC);
  localparam logic [31:0] H_ACT        = 32'(H_RES);
  localparam logic [31:0] V_ACT        = 32'(V_RES);

  localparam logic [OW-1:0] RST_VAL = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0,
                                       {X_W{1'b0}}, {Y_W{1'b0}}, 3'b000};

  if (H_RES == 0 || V_RES == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_geom
    $error("dvi_timing_gen: H_RES, V_RES, H_SYNC and V_SYNC must be non-zero");
  end
  if (PIPE > 8) begin : g_bad_pipe
    $error("dvi_timing_gen: PIPE must be in 0..8");
  end

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  logic [OW-1:0]  stage_q [PIPE+1];
  logic [OW-1:0]  stage_d [PIPE+1];

  logic [31:0] h_ext, v_ext;
  logic        hs_act, vs_act, de, ls, fs;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    h_ext  = 32'(h_q);
    v_ext  = 32'(v_q);
    hs_act = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
    vs_act = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
    de     = (h_ext < H_ACT) && (v_ext < V_ACT);
    ls     = pix_en && (h_q == '0);
    fs     = ls && (v_q == '0);
    stage_d[0] = {(hs_act ? H_SYNC_POL : ~H_SYNC_POL),
                  (vs_act ? V_SYNC_POL : ~V_SYNC_POL),
                  de, h_q, v_q, pix_en, ls, fs};
    for (int i = 1; i <= int'(PIPE); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stages run every clk so strobes stay one clk wide under a sparse pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      for (int i = 0; i <= int'(PIPE); i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      for (int i = 0; i <= int'(PIPE); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign {hsync, vsync, display_on, x, y, pix_tick, line_start, frame_start} = stage_q[PIPE];

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Self-checking bench for dvi_timing_gen on a small raster, compared against
// a pixel-index reference model every clk.
module tb_dvi_timing_gen;

  localparam int unsigned H_RES = 8,  H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int unsigned V_RES = 5,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam bit          H_POL = 1'b1, V_POL = 1'b0;
  localparam int unsigned PIPE  = 2;
  localparam int unsigned HT = H_RES + H_FP + H_SYNC + H_BP;  // 15
  localparam int unsigned VT = V_RES + V_FP + V_SYNC + V_BP;  // 9
  localparam int unsigned XW = $clog2(HT);
  localparam int unsigned YW = $clog2(VT);
  localparam int unsigned OW = 6 + XW + YW;
  localparam logic [OW-1:0] RST_EXP = {~H_POL, ~V_POL, 1'b0, {XW{1'b0}}, {YW{1'b0}}, 3'b000};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0;
  logic          hsync, vsync, display_on, pix_tick, line_start, frame_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  int errors = 0;
  int checks = 0;

  int unsigned    n_pix;          // pixel index within the frame
  logic [OW-1:0]  exp_pipe [PIPE+1];

  always #5 clk = ~clk;

  dvi_timing_gen #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_SYNC_POL(H_POL), .V_SYNC_POL(V_POL), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .x(x), .y(y), .pix_tick(pix_tick),
    .line_start(line_start), .frame_start(frame_start)
  );

  function automatic logic [OW-1:0] ref_decode(input int unsigned n, input logic p);
    int unsigned h, v;
    logic hs, vs, de;
    h  = n % HT;
    v  = n / HT;
    hs = (h >= H_RES + H_FP && h < H_RES + H_FP + H_SYNC) ? H_POL : ~H_POL;
    vs = (v >= V_RES + V_FP && v < V_RES + V_FP + V_SYNC) ? V_POL : ~V_POL;
    de = (h < H_RES) && (v < V_RES);
    return {hs, vs, de, XW'(h), YW'(v), p, p && (h == 0), p && (n == 0)};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {hsync, vsync, display_on, x, y, pix_tick, line_start, frame_start};
  endfunction

  task automatic model_step(input logic r, input logic p);
    if (r) begin
      for (int i = 0; i <= int'(PIPE); i++) exp_pipe[i] = RST_EXP;
      n_pix = 0;
    end else begin
      for (int i = int'(PIPE); i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
      exp_pipe[0] = ref_decode(n_pix, p);
      if (p) n_pix = (n_pix + 1) % (HT * VT);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cycle(input logic r, input logic p);
    logic [OW-1:0] obs;
    rst    = r;
    pix_en = p;
    @(posedge clk);
    model_step(r, p);
    @(negedge clk);
    obs = observed();
    checks++;
    assert (obs === exp_pipe[PIPE]) else begin
      errors++;
      $error("FAIL cycle_cmp t=%0t obs=%h exp=%h", $time, obs, exp_pipe[PIPE]);
    end
  endtask

  task automatic check_start_latency(input string tag);
    int  lat;
    bit  found;
    lat   = 0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, 1'b1);
      lat++;
      if (frame_start === 1'b1) found = 1;
    end
    checks++;
    assert (found && lat == int'(PIPE) + 1 && x === '0 && y === '0 && display_on === 1'b1) else begin
      errors++;
      $error("FAIL %s found=%0d latency=%0d expected=%0d x=%0d y=%0d de=%b",
             tag, found, lat, PIPE + 1, x, y, display_on);
    end
  endtask

  initial begin
    n_pix = 0;
    for (int i = 0; i <= int'(PIPE); i++) exp_pipe[i] = RST_EXP;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    checks++;
    assert (observed() === RST_EXP) else begin
      errors++;
      $error("FAIL reset_values obs=%h exp=%h", observed(), RST_EXP);
    end

    check_start_latency("first_frame_start");

    // continuous enable: more than two full frames including the double wrap
    for (int i = 0; i < 2 * int'(HT * VT) + 20; i++) cycle(1'b0, 1'b1);

    // alternate-clk enable
    for (int i = 0; i < 300; i++) cycle(1'b0, i[0]);

    // random sparse enable
    for (int i = 0; i < 500; i++) cycle(1'b0, ($urandom_range(0, 3) != 0));

    // reset mid-frame at (9,4), held with pix_en=1 to exercise priority
    begin
      bit reached;
      reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
        if (n_pix == 4 * HT + 9) reached = 1;
        else cycle(1'b0, 1'b1);
      end
      checks++;
      assert (reached) else begin
        errors++;
        $error("FAIL reach_mid_frame n=%0d required=%0d", n_pix, 4 * HT + 9);
      end
    end
    cycle(1'b1, 1'b1);
    checks++;
    assert (observed() === RST_EXP) else begin
      errors++;
      $error("FAIL mid_reset_values obs=%h exp=%h", observed(), RST_EXP);
    end
    check_start_latency("restart_frame_start");

    for (int i = 0; i < int'(HT * VT) + 10; i++) cycle(1'b0, ($urandom_range(0, 1) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
